uart_rx_with_buffer: RTL and testbench
======================================

UART_RX_WITH_BUFFER -- requirements
Module: uart_rx_with_buffer

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clk cycles per bit (100 MHz / 115200).
REQ-002 SHALL have parameter DEPTH, default 16, receive FIFO entries; power of two, 2..128.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port rd_en  input  1  pop request; honoured only while rd_valid=1.
REQ-007 SHALL have port rd_data  output  8  FIFO head byte, first-word fall-through.
REQ-008 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  bytes held.
REQ-010 SHALL have port framing_error  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port parity_error  output  1  one-cycle pulse on a parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: when rxs=0, SHALL load the bit counter with CLK_PER_BIT/2-1 and go to START.
REQ-016 START: at counter 0, rxs=1 SHALL be treated as a glitch (return to IDLE, no output).
REQ-017 START: at counter 0, rxs=0 SHALL go to DATA and reload the counter with CLK_PER_BIT-1.
REQ-018 DATA: SHALL sample 8 bits LSB first, one per counter expiry, so each sample falls mid-bit.
REQ-019 After bit 7 SHALL go to PARITY when UART_RX_PARITY_EN is defined, else to STOP.
REQ-020 STOP: sample rxs=1 with no errors SHALL write the byte into the FIFO and return to IDLE on the next cycle.
REQ-021 STOP: sample rxs=0 SHALL pulse framing_error, discard the byte and go to BREAK.
REQ-022 BREAK: SHALL stay until rxs=1, then go to IDLE; a held-low line yields exactly one framing_error.
REQ-023 Write latency: rd_valid and count SHALL update on the cycle after the stop-bit sample.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-025 Write when count=DEPTH and rd_en=0: byte SHALL be dropped, overflow pulsed, and FIFO contents unchanged.
REQ-026 Write and pop in the same cycle, including when count=DEPTH: both SHALL occur and count SHALL be unchanged.
REQ-027 rd_en while rd_valid=0 SHALL be ignored.
REQ-028 rd_data SHALL be don't-care while rd_valid=0.
REQ-029 Error pulses SHALL be mutually exclusive per frame; priority is framing, then parity, then overflow.

Reset
REQ-030 rst_n=0 SHALL asynchronously force:
- FSM to IDLE;
- counters and FIFO pointers to 0;
- synchronizer flops to 1;
- rd_valid=0, count=0, rd_data=0x00;
- all error pulses to 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial byte.
REQ-032 After reset release, a frame already in progress SHALL be treated as a glitch or framing error, never as valid data.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: a PARITY state SHALL sample a 9th bit between DATA and STOP.
REQ-034 Parity SHALL be even; on mismatch with a good stop bit: pulse parity_error and discard the byte.
REQ-035 Macro UART_RX_PARITY_EN undefined: frame SHALL be 8N1, PARITY state absent, parity_error constant 0.

Verification
REQ-036 Byte test: send 0x55 then 0xA3 at 868 clk/bit -> rd_valid=1, count=2, rd_data=0x55; after one rd_en -> rd_data=0xA3.
REQ-037 Glitch test: rx low for 200 clk, then high -> no write, count=0, no error pulse.
REQ-038 Framing test: send 0x3C with stop bit 0, line held low 20000 clk -> exactly one framing_error, count=0; next good 0x3C is accepted.
REQ-039 Overflow test: send 17 bytes 0x00..0x10 with no reads -> one overflow on the last byte, count=16; reads return 0x00..0x0F.
REQ-040 Full-plus-pop test: with count=16, hold rd_en=1 during the stop sample of 0x77 -> no overflow, count=16, 0x77 ends up last.
REQ-041 Reset and parity test: assert rst_n=0 during bit 4 -> count=0 afterwards. With UART_RX_PARITY_EN, 0x07 sent with parity 0 -> parity_error and byte discarded; parity 1 -> byte accepted.

Source files
------------

// File: rtl/uart_rx_with_buffer.sv
// 8N1 UART receiver feeding a first-word fall-through receive FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit checked before the stop bit).
module uart_rx_with_buffer #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     framing_error,
    output logic                     overflow,
    output logic                     parity_error
);

    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   HALF_LOAD  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_LOAD  = CW'(CLK_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_e;

    state_e          state_q, state_d;
    logic            rxMeta_q, rxs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic            parBit_q, parBit_d;
`endif
    logic            wrReq, feReq, peReq;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            pop, full, accept, ovReq;
    logic            fe_q, ov_q, pe_q;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxs_q    <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxs_q    <= rxMeta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
`ifdef UART_RX_PARITY_EN
            parBit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
`ifdef UART_RX_PARITY_EN
            parBit_q <= parBit_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
`ifdef UART_RX_PARITY_EN
        parBit_d = parBit_q;
`endif
        wrReq    = 1'b0;
        feReq    = 1'b0;
        peReq    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d    = FULL_LOAD;
                    bitIdx_d = 3'd0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d  = {rxs_q, shift_q[7:1]};
                    cnt_d    = FULL_LOAD;
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    parBit_d = rxs_q;
                    cnt_d    = FULL_LOAD;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs_q) begin
                    feReq   = 1'b1;
                    state_d = BREAK;
                end else begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (^{shift_q, parBit_q}) begin
                        peReq = 1'b1;
                    end else begin
                        wrReq = 1'b1;
                    end
`else
                    wrReq = 1'b1;
`endif
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign pop    = rd_en && (count_q != '0);
    assign full   = (count_q == FULL_COUNT);
    assign accept = wrReq && (!full || pop);
    assign ovReq  = wrReq && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            if (accept) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
            fe_q    <= feReq;
            ov_q    <= ovReq;
            pe_q    <= peReq;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wrPtr_q] <= shift_q;
        end
    end

    assign rd_valid      = (count_q != '0);
    assign rd_data       = rd_valid ? mem_q[rdPtr_q] : 8'h00;
    assign count         = count_q;
    assign framing_error = fe_q;
    assign overflow      = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = pe_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_with_buffer.sv
// Directed, table-driven bench for uart_rx_with_buffer; a short bit time keeps the run small.
// Builds for both the default 8N1 and the UART_RX_PARITY_EN 8E1 configuration.
`timescale 1ns/1ps
module tb_uart_rx_with_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int HALF  = CPB / 2 - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       framing_error;
    logic       overflow;
    logic       parity_error;

    int testsRun  = 0;
    int failCount = 0;
    int feCnt = 0;
    int ovCnt = 0;
    int peCnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         holdLow;
        logic       popBefore;
        int         expCount;
        int         expHead;
        int         expFe;
    } frameVec_t;

    frameVec_t vecs[5];

    uart_rx_with_buffer #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .framing_error(framing_error),
        .overflow     (overflow),
        .parity_error (parity_error)
    );

    always #5 clk = ~clk;

    // Count every error pulse away from the active edge.
    always @(negedge clk) begin
        if (framing_error) feCnt++;
        if (overflow)      ovCnt++;
        if (parity_error)  peCnt++;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one frame; popAtStop raises rd_en exactly on the DUT's stop-bit sample edge.
    task automatic applyStimulus(input logic [7:0] data, input logic parBit,
                                 input logic stopBit, input bit popAtStop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = parBit;
        repeat (CPB) @(negedge clk);
`else
        if (parBit === 1'bx) rx = 1'b1;
`endif
        rx = stopBit;
        if (popAtStop) begin
            repeat (3 + HALF) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (CPB - 4 - HALF) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic popByte(input string name, input int expected);
        @(negedge clk);
        checkOutput(name, int'(rd_data), expected);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int feBase, ovBase, peBase;

        vecs[0] = '{8'h55, 1'b1, 0,     1'b0, 1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b1, 0,     1'b0, 2, 8'h55, 0};
        vecs[2] = '{8'h3C, 1'b0, 20000, 1'b1, 1, 8'hA3, 1};
        vecs[3] = '{8'h3C, 1'b1, 0,     1'b1, 1, 8'h3C, 0};
        vecs[4] = '{8'hC3, 1'b1, 0,     1'b0, 2, 8'h3C, 0};

        rst_n = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("reset rd_valid", int'(rd_valid), 0);
        checkOutput("reset count", int'(count), 0);
        checkOutput("reset rd_data", int'(rd_data), 0);
        checkOutput("reset pulses", int'({framing_error, overflow, parity_error}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Pop on an empty FIFO must not move anything.
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        checkOutput("empty pop count", int'(count), 0);
        checkOutput("empty pop rd_valid", int'(rd_valid), 0);

        // Start bit shorter than half a bit time.
        feBase = feCnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch count", int'(count), 0);
        checkOutput("glitch framing", feCnt - feBase, 0);

        foreach (vecs[v]) begin
            feBase = feCnt;
            ovBase = ovCnt;
            if (vecs[v].popBefore) begin
                @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
            applyStimulus(vecs[v].data, ^vecs[v].data, vecs[v].stopBit, 1'b0);
            if (vecs[v].holdLow > 0) begin
                repeat (vecs[v].holdLow) @(negedge clk);
                rx = 1'b1;
                repeat (2 * CPB) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            checkOutput($sformatf("vec%0d count", v), int'(count), vecs[v].expCount);
            checkOutput($sformatf("vec%0d rd_valid", v), int'(rd_valid), 1);
            checkOutput($sformatf("vec%0d head", v), int'(rd_data), vecs[v].expHead);
            checkOutput($sformatf("vec%0d framing", v), feCnt - feBase, vecs[v].expFe);
            checkOutput($sformatf("vec%0d overflow", v), ovCnt - ovBase, 0);
        end

        popByte("drain 3C", 8'h3C);
        popByte("drain C3", 8'hC3);
        @(negedge clk);
        checkOutput("drained count", int'(count), 0);

        // Fill past capacity with no reads.
        ovBase = ovCnt;
        for (int b = 0; b <= DEPTH; b++) begin
            applyStimulus(8'(b), ^(8'(b)), 1'b1, 1'b0);
        end
        repeat (3) @(negedge clk);
        checkOutput("overflow pulses", ovCnt - ovBase, 1);
        checkOutput("overflow count", int'(count), DEPTH);
        checkOutput("overflow head", int'(rd_data), 8'h00);

        // Write and pop on the same edge while full.
        ovBase = ovCnt;
        applyStimulus(8'h77, ^(8'h77), 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("full+pop overflow", ovCnt - ovBase, 0);
        checkOutput("full+pop count", int'(count), DEPTH);
        for (int b = 1; b < DEPTH; b++) begin
            popByte($sformatf("drain %0d", b), b);
        end
        popByte("drain last 77", 8'h77);
        @(negedge clk);
        checkOutput("final drain count", int'(count), 0);
        checkOutput("final drain rd_valid", int'(rd_valid), 0);

        // Reset during data bit 4 of a frame whose tail is all ones.
        applyStimulus(8'h11, ^(8'h11), 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre-reset count", int'(count), 1);
        feBase = feCnt;
        fork
            applyStimulus(8'hF8, ^(8'hF8), 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                checkOutput("mid-frame reset count", int'(count), 0);
                checkOutput("mid-frame reset rd_data", int'(rd_data), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (3 * CPB) @(negedge clk);
        checkOutput("post-reset count", int'(count), 0);
        checkOutput("post-reset framing", feCnt - feBase, 0);

`ifdef UART_RX_PARITY_EN
        peBase = peCnt;
        applyStimulus(8'h07, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("bad parity pulse", peCnt - peBase, 1);
        checkOutput("bad parity count", int'(count), 0);
        peBase = peCnt;
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("good parity pulse", peCnt - peBase, 0);
        checkOutput("good parity count", int'(count), 1);
        checkOutput("good parity head", int'(rd_data), 8'h07);
`else
        peBase = 0;
        checkOutput("parity_error never pulses", peCnt - peBase, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
